// File: rtl/mmc_pkg.sv
// mmc_pkg: shared state encoding and MMC frame/R1 constants for the command responder
package mmc_pkg;
    typedef enum logic [2:0] {IDLE, COLL, CHK, CORE, WAIT, RSP} state_e;
    localparam logic [7:0] R1_ILLEGAL = 8'h04;
    localparam logic [7:0] R1_CRC_ERR = 8'h08;
    localparam int         FRAME_LEN  = 6;
    localparam logic [6:0] CRC7_POLY  = 7'h09;
    localparam logic [1:0] START_BITS = 2'b01;
    localparam logic [7:0] IDLE_BYTE  = 8'hFF;
endpackage

// File: rtl/mmc_crc7_byte.sv
// mmc_crc7_byte: one byte of CRC7 (x^7+x^3+1), MSB first, eight LFSR steps unrolled
module mmc_crc7_byte
    import mmc_pkg::*;
(
    input  logic [6:0] crc_in,
    input  logic [7:0] byte_in,
    output logic [6:0] crc_out
);
    // shift the byte through the LFSR one bit at a time
    always_comb begin
        crc_out = crc_in;
        for (int i = 7; i >= 0; i--)
            crc_out = {crc_out[5:0], 1'b0} ^ ((crc_out[6] ^ byte_in[i]) ? CRC7_POLY : 7'h00);
    end
endmodule

// File: rtl/mmc_cmd_rsp.sv
// mmc_cmd_rsp: collects 6-byte MMC command frames, hands them to the core, returns R1 after NCR (CRC check via MMC_CMD_CRC_CHK_EN)
module mmc_cmd_rsp
    import mmc_pkg::*;
#(
    parameter int NCR_CYC = 8,
    parameter int TO_CYC  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a2b_0,
    input  logic [7:0]  a2b_1,
    output logic        b2a_0,
    output logic [7:0]  b2a_1,
    output logic        cmd_vld,
    input  logic        cmd_rdy,
    output logic [5:0]  cmd_idx,
    output logic [31:0] cmd_arg,
    input  logic        rsp_vld,
    input  logic [7:0]  rsp_r1,
    output logic        drop_err
);
    localparam logic [15:0] TO_LAST  = 16'(TO_CYC - 1);
    localparam logic [7:0]  NCR_LAST = 8'(NCR_CYC - 1);
    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic [15:0] to_q, to_d;
    logic [7:0]  ncr_q, ncr_d;
    logic [7:0]  r1_q, r1_d;
    logic        vld_q, vld_d;
    logic        drop_q, drop_d;
    logic        end_q, end_d;
`ifdef MMC_CMD_CRC_CHK_EN
    logic [6:0]  crc_q, crc_d, crc_nxt;
    logic        ok_q, ok_d;
    mmc_crc7_byte u_crc (
        .crc_in  (state_q == IDLE ? 7'h00 : crc_q),
        .byte_in (a2b_1),
        .crc_out (crc_nxt)
    );
`endif
    assign b2a_0    = state_q == RSP;
    assign b2a_1    = b2a_0 ? r1_q : IDLE_BYTE;
    assign cmd_vld  = vld_q;
    assign cmd_idx  = idx_q;
    assign cmd_arg  = arg_q;
    assign drop_err = drop_q;
    // frame collection, check, core handshake and NCR countdown
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        arg_d   = arg_q;
        to_d    = to_q;
        ncr_d   = ncr_q;
        r1_d    = r1_q;
        vld_d   = vld_q;
        drop_d  = drop_q;
        end_d   = end_q;
`ifdef MMC_CMD_CRC_CHK_EN
        crc_d   = crc_q;
        ok_d    = ok_q;
`endif
        case (state_q)
            IDLE: if (a2b_0 && a2b_1[7:6] == START_BITS) begin
                idx_d   = a2b_1[5:0];
                cnt_d   = 3'd1;
                to_d    = '0;
                state_d = COLL;
`ifdef MMC_CMD_CRC_CHK_EN
                crc_d   = crc_nxt;
`endif
            end
            COLL: if (a2b_0) begin
                to_d = '0;
                if (cnt_q == 3'(FRAME_LEN - 1)) begin
                    end_d   = a2b_1[0];
                    state_d = CHK;
`ifdef MMC_CMD_CRC_CHK_EN
                    ok_d    = a2b_1[7:1] == crc_q;
`endif
                end else begin
                    arg_d = {arg_q[23:0], a2b_1};
                    cnt_d = cnt_q + 3'd1;
`ifdef MMC_CMD_CRC_CHK_EN
                    crc_d = crc_nxt;
`endif
                end
            end else if (to_q == TO_LAST) begin
                drop_d  = 1'b1;
                state_d = IDLE;
            end else begin
                to_d = to_q + 16'd1;
            end
            CHK: begin
                ncr_d = NCR_LAST;
                if (!end_q) begin
                    r1_d    = R1_ILLEGAL;
                    state_d = WAIT;
                end
`ifdef MMC_CMD_CRC_CHK_EN
                else if (!ok_q) begin
                    r1_d    = R1_CRC_ERR;
                    state_d = WAIT;
                end
`endif
                else begin
                    vld_d   = 1'b1;
                    state_d = CORE;
                end
            end
            CORE: begin
                if (vld_q && cmd_rdy) vld_d = 1'b0;
                if (rsp_vld && (!vld_q || cmd_rdy)) begin
                    r1_d    = rsp_r1 & 8'h7F;
                    ncr_d   = NCR_LAST;
                    state_d = WAIT;
                end
            end
            WAIT: if (ncr_q == 8'd0) state_d = RSP; else ncr_d = ncr_q - 8'd1;
            default: state_d = IDLE;
        endcase
        if (a2b_0 && state_q inside {CHK, CORE, WAIT, RSP}) drop_d = 1'b1;
    end
    // state registers, cleared asynchronously so a reset aborts any frame or response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            arg_q   <= '0;
            to_q    <= '0;
            ncr_q   <= '0;
            r1_q    <= IDLE_BYTE;
            vld_q   <= 1'b0;
            drop_q  <= 1'b0;
            end_q   <= 1'b0;
`ifdef MMC_CMD_CRC_CHK_EN
            crc_q   <= '0;
            ok_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            arg_q   <= arg_d;
            to_q    <= to_d;
            ncr_q   <= ncr_d;
            r1_q    <= r1_d;
            vld_q   <= vld_d;
            drop_q  <= drop_d;
            end_q   <= end_d;
`ifdef MMC_CMD_CRC_CHK_EN
            crc_q   <= crc_d;
            ok_q    <= ok_d;
`endif
        end
    end
endmodule

// File: tb/tb_mmc_cmd_rsp.sv
// tb_mmc_cmd_rsp: table-driven and randomized frames against a frame-level reference model
module tb_mmc_cmd_rsp;
    localparam int NCR = 8;
    localparam int TO  = 1024;
    logic        clk = 1'b0, rst = 1'b1;
    logic        a2b_0 = 1'b0, cmd_rdy = 1'b0, rsp_vld = 1'b0;
    logic [7:0]  a2b_1 = 8'hFF, rsp_r1 = 8'h00;
    logic        b2a_0, cmd_vld, drop_err;
    logic [7:0]  b2a_1;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    int          vectors = 0, miscompares = 0;
    logic        exp_drop = 1'b0;
    logic        crc_en;

    mmc_cmd_rsp #(.NCR_CYC(NCR), .TO_CYC(TO)) dut (
        .clk(clk), .rst(rst), .a2b_0(a2b_0), .a2b_1(a2b_1), .b2a_0(b2a_0), .b2a_1(b2a_1),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
        .rsp_vld(rsp_vld), .rsp_r1(rsp_r1), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] fb;
        int          first;
        logic [7:0]  r1;
        int          rdy_dly;
        int          rsp_dly;
        logic        inj;
        logic        rsp_start;
        logic        exp_vld;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [7:0]  exp_r1;
    } vec_t;

    vec_t tbl[6];
    vec_t v;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        a2b_0 = 1'b1;
        a2b_1 = b;
        tick();
        a2b_0 = 1'b0;
        a2b_1 = 8'hFF;
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c = 7'h00;
        logic       fb;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_drop = 1'b0;
    endtask

    task automatic run(input vec_t t);
        int   k = 0;
        logic bad = 1'b0;
        for (int i = t.first; i < 6; i++) send_byte(t.fb[47-8*i -: 8]);
        chk("chk_cycle_vld", 64'(cmd_vld), 64'(0));
        if (t.exp_vld) begin
            tick();
            chk("cmd_vld", 64'(cmd_vld), 64'(1));
            chk("cmd_idx", 64'(cmd_idx), 64'(t.idx));
            chk("cmd_arg", 64'(cmd_arg), 64'(t.arg));
            for (int d = 0; d < t.rdy_dly; d++) begin
                if (t.inj && d == 0) begin
                    a2b_0 = 1'b1;
                    a2b_1 = 8'h51;
                end
                tick();
                a2b_0 = 1'b0;
                a2b_1 = 8'hFF;
                if (cmd_vld !== 1'b1 || cmd_idx !== t.idx || cmd_arg !== t.arg) bad = 1'b1;
            end
            chk("cmd_hold", 64'(bad), 64'(0));
            cmd_rdy = 1'b1;
            if (t.rsp_dly == 0) begin
                rsp_vld = 1'b1;
                rsp_r1  = t.r1;
            end
            tick();
            cmd_rdy = 1'b0;
            rsp_vld = 1'b0;
            chk("cmd_vld_drop", 64'(cmd_vld), 64'(0));
            if (t.rsp_dly > 0) begin
                repeat (t.rsp_dly - 1) tick();
                rsp_vld = 1'b1;
                rsp_r1  = t.r1;
                tick();
                rsp_vld = 1'b0;
            end
            k = 1;
        end
        bad = 1'b0;
        while (b2a_0 !== 1'b1 && k < NCR + 10) begin
            if (b2a_1 !== 8'hFF || cmd_vld !== 1'b0) bad = 1'b1;
            tick();
            k++;
        end
        chk("idle_outputs", 64'(bad), 64'(0));
        chk("ncr_latency", 64'(k), 64'(NCR + 1));
        chk("r1", 64'(b2a_1), 64'(t.exp_r1));
        if (t.rsp_start) begin
            a2b_0 = 1'b1;
            a2b_1 = 8'h40;
            exp_drop = 1'b1;
        end
        tick();
        a2b_0 = 1'b0;
        a2b_1 = 8'hFF;
        chk("rsp_end", {55'd0, b2a_0, b2a_1}, {55'd0, 1'b0, 8'hFF});
        if (t.inj) exp_drop = 1'b1;
        chk("drop_err", 64'(drop_err), 64'(exp_drop));
    endtask

    initial begin
`ifdef MMC_CMD_CRC_CHK_EN
        crc_en = 1'b1;
`else
        crc_en = 1'b0;
`endif
        tbl[0] = '{48'h40_00_00_00_00_95, 0, 8'h01, 0, 0, 1'b0, 1'b0, 1'b1, 6'd0, 32'h0, 8'h01};
        tbl[1] = '{48'h48_00_00_01_AA_87, 0, 8'h81, 3, 2, 1'b0, 1'b0, 1'b1, 6'd8, 32'h1AA, 8'h01};
        tbl[2] = crc_en ? '{48'h40_00_00_00_00_97, 0, 8'h05, 0, 0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 8'h08}
                        : '{48'h40_00_00_00_00_97, 0, 8'h05, 0, 0, 1'b0, 1'b0, 1'b1, 6'd0, 32'h0, 8'h05};
        tbl[3] = '{48'h40_00_00_00_00_94, 0, 8'h01, 0, 0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 8'h04};
        tbl[4] = '{48'h48_00_00_01_AA_87, 0, 8'h7E, 2, 1, 1'b1, 1'b0, 1'b1, 6'd8, 32'h1AA, 8'h7E};
        tbl[5] = '{48'h40_00_00_00_00_95, 0, 8'h01, 1, 0, 1'b0, 1'b1, 1'b1, 6'd0, 32'h0, 8'h01};
        repeat (2) tick();
        chk("rst_b2a_0", 64'(b2a_0), 64'(0));
        chk("rst_b2a_1", 64'(b2a_1), 64'(8'hFF));
        chk("rst_cmd", {25'd0, cmd_vld, cmd_idx, cmd_arg}, 64'(0));
        chk("rst_drop", 64'(drop_err), 64'(0));
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) run(tbl[i]);
        for (int r = 0; r < 20; r++) begin
            logic [5:0] idx;
            logic [31:0] arg;
            logic [6:0] c, cf;
            logic [7:0] junk;
            logic endb, badc;
            junk = 8'($urandom);
            if (junk[7:6] == 2'b01) junk[7] = 1'b1;
            send_byte(junk);
            repeat ($urandom_range(0, 3)) tick();
            idx  = 6'($urandom);
            arg  = $urandom;
            c    = crc7({2'b01, idx, arg});
            endb = $urandom_range(0, 3) != 0;
            badc = $urandom_range(0, 3) == 0;
            cf   = badc ? c ^ 7'($urandom_range(1, 127)) : c;
            v = '{{2'b01, idx, arg, cf, endb}, 0, 8'($urandom), $urandom_range(0, 3),
                  $urandom_range(0, 3), 1'b0, 1'b0, 1'b1, idx, arg, 8'h00};
            if (!endb) begin
                v.exp_vld = 1'b0;
                v.exp_r1  = 8'h04;
            end else if (crc_en && badc) begin
                v.exp_vld = 1'b0;
                v.exp_r1  = 8'h08;
            end else begin
                v.exp_r1 = {1'b0, v.r1[6:0]};
            end
            run(v);
        end
        run(tbl[4]);
        run(tbl[5]);
        run(tbl[0]);
        do_reset();
        send_byte(8'h40);
        send_byte(8'h00);
        repeat (TO - 1) tick();
        chk("to_pre_expiry", 64'(drop_err), 64'(0));
        tick();
        chk("to_expired", 64'(drop_err), 64'(1));
        begin
            logic seen = 1'b0;
            for (int i = 0; i < NCR + 4; i++) begin
                if (b2a_0 !== 1'b0) seen = 1'b1;
                tick();
            end
            chk("to_no_rsp", 64'(seen), 64'(0));
        end
        exp_drop = 1'b1;
        run(tbl[0]);
        do_reset();
        send_byte(8'h40);
        send_byte(8'h00);
        repeat (TO - 1) tick();
        send_byte(8'h00);
        v = tbl[0];
        v.first = 3;
        run(v);
        send_byte(8'h48);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'h87);
        tick();
        send_byte(8'h51);
        chk("busy_drop", 64'(drop_err), 64'(1));
        chk("busy_idx", 64'(cmd_idx), 64'(8));
        cmd_rdy = 1'b1;
        rsp_vld = 1'b1;
        rsp_r1  = 8'h01;
        tick();
        cmd_rdy = 1'b0;
        rsp_vld = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("async_b2a", {55'd0, b2a_0, b2a_1}, {55'd0, 1'b0, 8'hFF});
        chk("async_cmd", {25'd0, cmd_vld, cmd_idx, cmd_arg}, 64'(0));
        chk("async_drop", 64'(drop_err), 64'(0));
        tick();
        rst = 1'b0;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < NCR + 6; i++) begin
                if (b2a_0 !== 1'b0) seen = 1'b1;
                tick();
            end
            chk("rst_abort_no_rsp", 64'(seen), 64'(0));
        end
        exp_drop = 1'b0;
        run(tbl[1]);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
